stream_demux_nway: RTL

//  Registered, parametrised N-way demultiplexer with valid/ready handshake on every channel.

---
 rtl/stream_demux_nway_pkg.sv | 22 ++
 rtl/stream_demux_nway_if.sv | 32 +++
 rtl/stream_demux_nway_sel_decoder.sv | 23 ++
 rtl/stream_demux_nway.sv | 86 ++++++++
 4 files changed

// File: rtl/stream_demux_nway_pkg.sv
// Shared definitions for the N-way stream demultiplexer.
//   DEMUX_MAX_OUT : largest supported channel count
//   route_e       : how an accepted word is routed
//   demux_clog2   : ceil(log2(v)), used for parameter width checks
package stream_demux_nway_pkg;

    localparam int DEMUX_MAX_OUT = 32;

    typedef enum logic [1:0] {
        ROUTE_DROP    = 2'd0,
        ROUTE_UNICAST = 2'd1,
        ROUTE_BCAST   = 2'd2
    } route_e;

    function automatic int demux_clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction

endpackage

// File: rtl/stream_demux_nway_if.sv
// Handshake bundle for stream_demux_nway.
//   in_valid/in_ready/in_data/in_sel/in_bcast : producer side
//   out_valid/out_ready/out_data              : consumer side, one valid/ready per channel
//   sel_err, busy                             : status
// slave  : the demux itself
// master : the environment (producer + consumers)
interface stream_demux_nway_if #(
    parameter int WIDTH   = 8,
    parameter int NUM_OUT = 4,
    parameter int SEL_W   = 2
) ();
    logic               in_valid;
    logic               in_ready;
    logic [WIDTH-1:0]   in_data;
    logic [SEL_W-1:0]   in_sel;
    logic               in_bcast;
    logic [NUM_OUT-1:0] out_valid;
    logic [NUM_OUT-1:0] out_ready;
    logic [WIDTH-1:0]   out_data;
    logic               sel_err;
    logic               busy;

    modport slave (
        input  in_valid, in_data, in_sel, in_bcast, out_ready,
        output in_ready, out_valid, out_data, sel_err, busy
    );

    modport master (
        output in_valid, in_data, in_sel, in_bcast, out_ready,
        input  in_ready, out_valid, out_data, sel_err, busy
    );
endinterface

// File: rtl/stream_demux_nway_sel_decoder.sv
// Combinational select decoder.
//   sel      : channel index
//   onehot   : one bit set at position sel when sel < NUM_OUT, else all zero
//   in_range : sel addresses an existing channel
module stream_demux_nway_sel_decoder #(
    parameter int NUM_OUT = 4,
    parameter int SEL_W   = 2
) (
    input  logic [SEL_W-1:0]   sel,
    output logic [NUM_OUT-1:0] onehot,
    output logic               in_range
);
    always_comb begin
        onehot   = '0;
        in_range = 1'b0;
        for (int i = 0; i < NUM_OUT; i++) begin
            if (sel == SEL_W'(i)) begin
                onehot[i] = 1'b1;
                in_range  = 1'b1;
            end
        end
    end
endmodule

// File: rtl/stream_demux_nway.sv
// Registered N-way demultiplexer with valid/ready on every channel.
// A word is routed to one channel (unicast) or all channels (broadcast) and
// held in a one-entry stage until every targeted channel has taken it.
//   clk, rst_n : clock (rising edge), asynchronous active-low reset
//   bus        : stream_demux_nway_if.slave handshake bundle
module stream_demux_nway
    import stream_demux_nway_pkg::*;
#(
    parameter int WIDTH   = 8,
    parameter int NUM_OUT = 4,
    parameter int SEL_W   = 2
) (
    input logic               clk,
    input logic               rst_n,
    stream_demux_nway_if.slave bus
);
    if (NUM_OUT < 2 || NUM_OUT > DEMUX_MAX_OUT || SEL_W < demux_clog2(NUM_OUT)
        || WIDTH < 1) begin : g_param_check
        $error("stream_demux_nway: illegal WIDTH/NUM_OUT/SEL_W combination");
    end

    logic [WIDTH-1:0]   data_q;
    logic [NUM_OUT-1:0] pending_q;
    logic [NUM_OUT-1:0] pending_d;
    logic               sel_err_q;
    logic [NUM_OUT-1:0] sel_onehot;
    logic               sel_in_range;
    logic               drain;
    logic               accept;
    route_e             route;

    stream_demux_nway_sel_decoder #(
        .NUM_OUT (NUM_OUT),
        .SEL_W   (SEL_W)
    ) u_sel_decoder (
        .sel      (bus.in_sel),
        .onehot   (sel_onehot),
        .in_range (sel_in_range)
    );

    // The stage is free when every channel still owed the word takes it now,
    // which lets a new word load on the same edge as the last acceptance.
    assign drain  = ((pending_q & ~bus.out_ready) == '0);
    assign accept = bus.in_valid & drain;

    always_comb begin
        route = ROUTE_DROP;
        if (bus.in_bcast) begin
            route = ROUTE_BCAST;
        end else if (sel_in_range) begin
            route = ROUTE_UNICAST;
        end
    end

    always_comb begin
        pending_d = pending_q & ~bus.out_ready;
        if (accept) begin
            case (route)
                ROUTE_BCAST:   pending_d = '1;
                ROUTE_UNICAST: pending_d = sel_onehot;
                default:       pending_d = '0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q    <= '0;
            pending_q <= '0;
            sel_err_q <= 1'b0;
        end else begin
            pending_q <= pending_d;
            // An out-of-range unicast is still handshaken, only flagged.
            sel_err_q <= accept && (route == ROUTE_DROP);
            if (accept) begin
                data_q <= bus.in_data;
            end
        end
    end

    assign bus.in_ready  = drain;
    assign bus.out_valid = pending_q;
    assign bus.out_data  = data_q;
    assign bus.busy      = |pending_q;
    assign bus.sel_err   = sel_err_q;
endmodule
